// File: rtl/zc_pkg.sv
// Shared definitions for the zero-crossing half-period averager:
// FSM state encoding, window-length clamp and accumulator sizing.
package zc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int ZC_COUNTER_SIZE = 32;
  localparam int ZC_LOG_MAX_AVG  = 8;
  localparam int ZC_TIMEOUT_SIZE = 32;
  localparam int ZC_ACC_W        = ZC_COUNTER_SIZE + ZC_LOG_MAX_AVG;

  function automatic int acc_width(input int counter_size, input int log_max_avg);
    return counter_size + log_max_avg;
  endfunction

  function automatic logic [7:0] clamp_log(input logic [7:0] log_avg_len,
                                           input logic [7:0] log_max_avg);
    return (log_avg_len > log_max_avg) ? log_max_avg : log_avg_len;
  endfunction

endpackage

// File: rtl/zc_window_timer.sv
// Stall timer for an open averaging window: counts cycles without an accepted
// sample and flags expiry one cycle before reaching the programmed timeout.
module zc_window_timer
  import zc_pkg::*;
#(
  parameter int TIMEOUT_SIZE = ZC_TIMEOUT_SIZE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [TIMEOUT_SIZE-1:0] timeout,
  input  logic                    restart,
  input  logic                    enable,
  output logic                    expire
);

  logic [TIMEOUT_SIZE-1:0] timer_r;

  // A sample arriving in the expiry cycle wins, so restart masks expire.
  assign expire = enable && !restart && (timeout != {TIMEOUT_SIZE{1'b0}}) &&
                  (timer_r == timeout - {{(TIMEOUT_SIZE-1){1'b0}}, 1'b1});

  // Idle-cycle counter; held at zero outside an open window.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      timer_r <= {TIMEOUT_SIZE{1'b0}};
    end else if (restart || !enable) begin
      timer_r <= {TIMEOUT_SIZE{1'b0}};
    end else begin
      timer_r <= timer_r + {{(TIMEOUT_SIZE-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/zc_period_avg.sv
// Averages 2^eff same-sign half-period counts from the zero-crossing detector
// and emits one floor-averaged count per window as a single-beat stream packet.
module zc_period_avg
  import zc_pkg::*;
#(
  parameter int COUNTER_SIZE = ZC_COUNTER_SIZE,
  parameter int LOG_MAX_AVG  = ZC_LOG_MAX_AVG,
  parameter int TIMEOUT_SIZE = ZC_TIMEOUT_SIZE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [7:0]              log_avg_len,
  input  logic [TIMEOUT_SIZE-1:0] timeout,
  input  logic [COUNTER_SIZE-1:0] i_tdata,
  input  logic                    i_tvalid,
  input  logic                    i_tlast,
  output logic                    i_tready,
  output logic [COUNTER_SIZE-1:0] o_tdata,
  output logic                    o_tvalid,
  output logic                    o_tlast,
  input  logic                    o_tready,
  output logic                    stale,
  output logic [15:0]             sign_restarts
);

  localparam int ACC_W = acc_width(COUNTER_SIZE, LOG_MAX_AVG);
  localparam int CNT_W = LOG_MAX_AVG + 1;

  state_t                    state_r, state_nxt_s;
  logic signed [ACC_W-1:0]   sum_r, sum_nxt_s, sext_s, acc_sum_s, shifted_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt_s, target_s;
  logic [7:0]                eff_r, eff_nxt_s, eff_idle_s;
  logic                      sign_r, sign_nxt_s;
  logic [COUNTER_SIZE-1:0]   odata_r, odata_nxt_s;
  logic                      ovalid_r, ovalid_nxt_s;
  logic                      stale_r, stale_nxt_s;
  logic [15:0]               restarts_r, restarts_nxt_s;
  logic                      accept_s, msb_s, expire_s, unused_s;

  assign unused_s      = i_tlast;
  assign msb_s         = i_tdata[COUNTER_SIZE-1];
  assign sext_s        = {{LOG_MAX_AVG{msb_s}}, i_tdata};
  assign acc_sum_s     = sum_r + sext_s;
  assign shifted_s     = acc_sum_s >>> eff_r;
  assign eff_idle_s    = clamp_log(log_avg_len, 8'(LOG_MAX_AVG));
  assign target_s      = {{(CNT_W-1){1'b0}}, 1'b1} << eff_r;
  assign i_tready      = (state_r != HOLD);
  assign accept_s      = i_tvalid && i_tready;
  assign o_tdata       = odata_r;
  assign o_tvalid      = ovalid_r;
  assign o_tlast       = ovalid_r;
  assign stale         = stale_r;
  assign sign_restarts = restarts_r;

  zc_window_timer #(.TIMEOUT_SIZE(TIMEOUT_SIZE)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .timeout (timeout),
    .restart (accept_s),
    .enable  (state_r == ACCUM),
    .expire  (expire_s)
  );

  // Next-state, accumulator and output-register update.
  always_comb begin
    state_nxt_s    = state_r;
    sum_nxt_s      = sum_r;
    cnt_nxt_s      = cnt_r;
    eff_nxt_s      = eff_r;
    sign_nxt_s     = sign_r;
    odata_nxt_s    = odata_r;
    ovalid_nxt_s   = ovalid_r;
    stale_nxt_s    = stale_r;
    restarts_nxt_s = restarts_r;
    case (state_r)
      IDLE: begin
        eff_nxt_s = eff_idle_s;
        if (accept_s) begin
          sum_nxt_s  = sext_s;
          cnt_nxt_s  = {{(CNT_W-1){1'b0}}, 1'b1};
          sign_nxt_s = msb_s;
          // A one-sample window completes immediately: pass the sample through.
          if (eff_idle_s == 8'd0) begin
            odata_nxt_s  = i_tdata;
            ovalid_nxt_s = 1'b1;
            state_nxt_s  = HOLD;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          if (msb_s != sign_r) begin
            sum_nxt_s  = sext_s;
            cnt_nxt_s  = {{(CNT_W-1){1'b0}}, 1'b1};
            sign_nxt_s = msb_s;
            if (restarts_r != 16'hFFFF) begin
              restarts_nxt_s = restarts_r + 16'd1;
            end else begin
              restarts_nxt_s = restarts_r;
            end
          end else if (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1} == target_s) begin
            sum_nxt_s    = acc_sum_s;
            cnt_nxt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            odata_nxt_s  = shifted_s[COUNTER_SIZE-1:0];
            ovalid_nxt_s = 1'b1;
            state_nxt_s  = HOLD;
          end else begin
            sum_nxt_s = acc_sum_s;
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (expire_s) begin
          sum_nxt_s   = {ACC_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          stale_nxt_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (o_tready) begin
          ovalid_nxt_s = 1'b0;
          stale_nxt_s  = 1'b0;
          sum_nxt_s    = {ACC_W{1'b0}};
          cnt_nxt_s    = {CNT_W{1'b0}};
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset and clear drop any partial window.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_r    <= IDLE;
      sum_r      <= {ACC_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      eff_r      <= 8'd0;
      sign_r     <= 1'b0;
      odata_r    <= {COUNTER_SIZE{1'b0}};
      ovalid_r   <= 1'b0;
      stale_r    <= 1'b0;
      restarts_r <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      sum_r      <= sum_nxt_s;
      cnt_r      <= cnt_nxt_s;
      eff_r      <= eff_nxt_s;
      sign_r     <= sign_nxt_s;
      odata_r    <= odata_nxt_s;
      ovalid_r   <= ovalid_nxt_s;
      stale_r    <= stale_nxt_s;
      restarts_r <= restarts_nxt_s;
    end
  end

endmodule
